// File: rtl/pintor_objetivo_if.sv
// Bus between the game master and the target painter: master control/position in,
// framebuffer write port and round status out.
interface pintor_objetivo_if;
  logic        pintar;
  logic        resetPintar;
  logic        hit;
  logic [7:0]  posX;
  logic [6:0]  posY;
  logic [2:0]  color;
  logic        wrEn;
  logic [14:0] wrAddr;
  logic [2:0]  wrData;
  logic        stop;
  logic        busy;

  modport master (
    output pintar, resetPintar, hit, posX, posY, color,
    input  wrEn, wrAddr, wrData, stop, busy
  );

  modport slave (
    input  pintar, resetPintar, hit, posX, posY, color,
    output wrEn, wrAddr, wrData, stop, busy
  );
endinterface

// File: rtl/pintor_objetivo.sv
// Target painter: draws a SIZExSIZE square, holds it until hit or timeout, pulses stop,
// then erases the same square to colour 0. One pixel per clock, all outputs registered.
module pintor_objetivo #(
  parameter int unsigned COLS        = 160,
  parameter int unsigned ROWS        = 120,
  parameter int unsigned SIZE        = 8,
  parameter int unsigned HOLD_CYCLES = 25_000_000
) (
  input logic              iClk,
  input logic              iReset,
  pintor_objetivo_if.slave bus
);

  localparam int unsigned CntW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned TimerW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [2:0] stIdle      = 3'd0;
  localparam logic [2:0] stDraw      = 3'd1;
  localparam logic [2:0] stHold      = 3'd2;
  localparam logic [2:0] stWaitErase = 3'd3;
  localparam logic [2:0] stErase     = 3'd4;

  logic [2:0]        stateQ, stateD;
  logic [CntW-1:0]   rowQ, rowD, colQ, colD;
  logic [TimerW-1:0] timerQ, timerD;
  logic [7:0]        x0Q, x0D;
  logic [6:0]        y0Q, y0D;
  logic [2:0]        colorQ, colorD;
  logic              wrEnQ, wrEnD, stopQ, stopD, busyQ, busyD;
  logic [14:0]       wrAddrQ, wrAddrD;
  logic [2:0]        wrDataQ, wrDataD;

  logic              scan;
  logic [7:0]        scanBaseX;
  logic [6:0]        scanBaseY;
  logic [2:0]        scanData;
  logic [31:0]       pixX, pixY, pixAddr;
  logic              lastPixel, inRange;

  assign lastPixel = (colQ == CntW'(SIZE - 1)) && (rowQ == CntW'(SIZE - 1));

  always_comb begin
    stateD    = stateQ;
    rowD      = rowQ;
    colD      = colQ;
    timerD    = timerQ;
    x0D       = x0Q;
    y0D       = y0Q;
    colorD    = colorQ;
    stopD     = 1'b0;
    scan      = 1'b0;
    scanBaseX = x0Q;
    scanBaseY = y0Q;
    scanData  = colorQ;

    case (stateQ)
      stIdle: begin
        if (bus.pintar) begin
          stateD    = stDraw;
          x0D       = bus.posX;
          y0D       = bus.posY;
          colorD    = bus.color;
          rowD      = '0;
          colD      = '0;
          // First pixel goes out the cycle right after the pulse, so use the live inputs.
          scan      = 1'b1;
          scanBaseX = bus.posX;
          scanBaseY = bus.posY;
          scanData  = bus.color;
        end
      end
      stDraw, stErase: begin
        if (lastPixel) begin
          stateD = (stateQ == stDraw) ? stHold : stIdle;
          timerD = '0;
        end else begin
          if (colQ == CntW'(SIZE - 1)) begin
            colD = '0;
            rowD = rowQ + CntW'(1);
          end else begin
            colD = colQ + CntW'(1);
          end
          scan     = 1'b1;
          scanData = (stateQ == stDraw) ? colorQ : 3'd0;
        end
      end
      stHold: begin
        timerD = timerQ + TimerW'(1);
        if (bus.hit || (timerQ == TimerW'(HOLD_CYCLES - 1))) begin
          stateD = stWaitErase;
          stopD  = 1'b1;
        end
      end
      stWaitErase: begin
        if (bus.resetPintar) begin
          stateD   = stErase;
          rowD     = '0;
          colD     = '0;
          scan     = 1'b1;
          scanData = 3'd0;
        end
      end
      default: stateD = stIdle;
    endcase

    pixX    = 32'(scanBaseX) + 32'(colD);
    pixY    = 32'(scanBaseY) + 32'(rowD);
    inRange = (pixX < COLS) && (pixY < ROWS);
    pixAddr = pixY * COLS + pixX;
    wrEnD   = scan && inRange;
    wrAddrD = wrEnD ? pixAddr[14:0] : 15'd0;
    wrDataD = wrEnD ? scanData : 3'd0;
    busyD   = (stateD == stDraw) || (stateD == stErase);
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      stateQ  <= stIdle;
      rowQ    <= '0;
      colQ    <= '0;
      timerQ  <= '0;
      x0Q     <= '0;
      y0Q     <= '0;
      colorQ  <= '0;
      wrEnQ   <= 1'b0;
      wrAddrQ <= '0;
      wrDataQ <= '0;
      stopQ   <= 1'b0;
      busyQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      rowQ    <= rowD;
      colQ    <= colD;
      timerQ  <= timerD;
      x0Q     <= x0D;
      y0Q     <= y0D;
      colorQ  <= colorD;
      wrEnQ   <= wrEnD;
      wrAddrQ <= wrAddrD;
      wrDataQ <= wrDataD;
      stopQ   <= stopD;
      busyQ   <= busyD;
    end
  end

  assign bus.wrEn   = wrEnQ;
  assign bus.wrAddr = wrAddrQ;
  assign bus.wrData = wrDataQ;
  assign bus.stop   = stopQ;
  assign bus.busy   = busyQ;

endmodule

// File: tb/tb_pintor_objetivo.sv
// Directed bench for pintor_objetivo with SIZE=2, HOLD_CYCLES=5 on a 160x120 framebuffer.
module tb_pintor_objetivo;

  logic iClk = 1'b0;
  logic iReset;
  int   tests = 0;
  int   fails = 0;

  pintor_objetivo_if bus ();

  pintor_objetivo #(
    .COLS       (160),
    .ROWS       (120),
    .SIZE       (2),
    .HOLD_CYCLES(5)
  ) dut (
    .iClk  (iClk),
    .iReset(iReset),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkWr(input string tag, input logic en, input int addr, input int data,
                       input logic busy);
    chk({tag, ".wrEn"}, 32'(bus.wrEn), 32'(en));
    chk({tag, ".wrAddr"}, 32'(bus.wrAddr), 32'(addr));
    chk({tag, ".wrData"}, 32'(bus.wrData), 32'(data));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
  endtask

  initial begin
    int addrs[4];

    // Reset with random inputs
    iReset          = 1'b1;
    bus.pintar      = 1'($urandom);
    bus.resetPintar = 1'($urandom);
    bus.hit         = 1'($urandom);
    bus.posX        = 8'($urandom);
    bus.posY        = 7'($urandom);
    bus.color       = 3'($urandom);
    tick();
    tick();
    chkWr("reset", 1'b0, 0, 0, 1'b0);
    chk("reset.stop", 32'(bus.stop), 0);

    iReset          = 1'b0;
    bus.pintar      = 1'b0;
    bus.hit         = 1'b1;
    bus.resetPintar = 1'b1;
    tick();
    tick();
    chkWr("idle_ignore", 1'b0, 0, 0, 1'b0);
    chk("idle_ignore.stop", 32'(bus.stop), 0);
    bus.hit         = 1'b0;
    bus.resetPintar = 1'b0;

    // Draw at (10,20) colour 5; pintar held into DRAW and position changed after latch
    bus.posX   = 8'd10;
    bus.posY   = 7'd20;
    bus.color  = 3'b101;
    bus.pintar = 1'b1;
    addrs      = '{3210, 3211, 3370, 3371};
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        bus.posX  = 8'd99;
        bus.color = 3'd2;
      end
      if (i == 1) bus.pintar = 1'b0;
      chkWr($sformatf("draw%0d", i), 1'b1, addrs[i], 5, 1'b1);
    end
    tick();
    chkWr("draw_end", 1'b0, 0, 0, 1'b0);

    // Timeout: stop exactly 5 cycles after HOLD entry, for one cycle
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("timeout_stop%0d", i), 32'(bus.stop), (i == 5) ? 1 : 0);
    end

    // Erase with posX changed: uses latched position, data 0
    bus.posX        = 8'd50;
    bus.resetPintar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.resetPintar = 1'b0;
      chkWr($sformatf("erase%0d", i), 1'b1, addrs[i], 0, 1'b1);
    end
    tick();
    chkWr("erase_end", 1'b0, 0, 0, 1'b0);

    // Hit round at (30,40)
    bus.posX   = 8'd30;
    bus.posY   = 7'd40;
    bus.color  = 3'd3;
    bus.pintar = 1'b1;
    addrs      = '{6430, 6431, 6590, 6591};
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.pintar = 1'b0;
      chkWr($sformatf("hdraw%0d", i), 1'b1, addrs[i], 3, 1'b1);
    end
    tick();
    chk("hold1.stop", 32'(bus.stop), 0);
    tick();
    chk("hold2.stop", 32'(bus.stop), 0);
    bus.hit = 1'b1;
    tick();
    chk("hit.stop", 32'(bus.stop), 1);
    bus.hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) bus.hit = 1'b1;
      chk($sformatf("after_hit%0d", i), 32'(bus.stop), 0);
    end
    bus.hit         = 1'b0;
    bus.resetPintar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.resetPintar = 1'b0;
      chkWr($sformatf("herase%0d", i), 1'b1, addrs[i], 0, 1'b1);
    end
    tick();
    chkWr("herase_end", 1'b0, 0, 0, 1'b0);

    // Clip at (159,119): one write only, scan still 4 cycles
    bus.posX   = 8'd159;
    bus.posY   = 7'd119;
    bus.color  = 3'd7;
    bus.pintar = 1'b1;
    tick();
    bus.pintar = 1'b0;
    chkWr("clip0", 1'b1, 19199, 7, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chkWr($sformatf("clip%0d", i), 1'b0, 0, 0, 1'b1);
    end
    tick();
    chkWr("clip_end", 1'b0, 0, 0, 1'b0);
    bus.hit = 1'b1;
    tick();
    bus.hit = 1'b0;
    chk("clip_hit.stop", 32'(bus.stop), 1);
    bus.resetPintar = 1'b1;
    tick();
    bus.resetPintar = 1'b0;
    chkWr("cerase0", 1'b1, 19199, 0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chkWr($sformatf("cerase%0d", i), 1'b0, 0, 0, 1'b1);
    end
    tick();
    chkWr("cerase_end", 1'b0, 0, 0, 1'b0);

    // Reset during the second write of a draw
    bus.posX   = 8'd5;
    bus.posY   = 7'd5;
    bus.color  = 3'd6;
    bus.pintar = 1'b1;
    tick();
    bus.pintar = 1'b0;
    chkWr("mid0", 1'b1, 805, 6, 1'b1);
    tick();
    chkWr("mid1", 1'b1, 806, 6, 1'b1);
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    chkWr("mid_reset", 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("mid_nostop%0d", i), 32'(bus.stop) | 32'(bus.wrEn), 0);
    end
    bus.posX   = 8'd0;
    bus.posY   = 7'd0;
    bus.color  = 3'd1;
    bus.pintar = 1'b1;
    addrs      = '{0, 1, 160, 161};
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.pintar = 1'b0;
      chkWr($sformatf("origin%0d", i), 1'b1, addrs[i], 1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
